// File: rtl/io_bus_sched_pkg.sv
// io_bus_sched_pkg
//   Shared types and helpers for the IO bus scheduler.
//   state_e   : scheduler states IDLE (bus released, arbitrating),
//               DRIVE (owner granted, beats accepted), TURN (bus released
//               for the turnaround interval).
//   cnt_width : bit width needed to hold the values 0..max_val (minimum 1).
package io_bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_bus_rr_arb.sv
// io_bus_rr_arb
//   Round-robin arbiter over NUM_REQ requesters. The priority pointer
//   names the requester searched first; it advances to the requester after
//   the current winner when i_update is pulsed.
//   Ports:
//     clk, resetn  : clock, asynchronous active-low reset (pointer -> 0)
//     i_req        : request vector
//     i_update     : advance the pointer past the current winner
//     o_winner     : one-hot winner (all zero when no request)
module io_bus_rr_arb
  import io_bus_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_winner
);

  localparam int PW = cnt_width(NUM_REQ - 1);

  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_src;
  logic [PW-1:0]      w_win_idx;

  // Thermometer mask of indices at or above the pointer. Requests in that
  // range win first; otherwise the search wraps to the unmasked vector.
  assign w_mask = ~((NUM_REQ'(1) << r_ptr) - NUM_REQ'(1));
  assign w_src  = (|(i_req & w_mask)) ? (i_req & w_mask) : i_req;

  // Lowest set bit of the selected vector.
  always_comb begin
    o_winner = w_src & (~w_src + NUM_REQ'(1));
  end

  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_winner[k]) w_win_idx = PW'(k);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (w_win_idx == PW'(NUM_REQ - 1)) ? '0 : w_win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/io_bus_sched.sv
// io_bus_sched
//   Shares one WIDTH-bit bidirectional IO bus between NUM_REQ requesters.
//   Bursts are granted round-robin, the bus is driven through per-bit
//   tristate controls, and a released-bus turnaround separates owners.
//   The bus is sampled into a monitor port every cycle.
//   Optional feature macro: IO_BUS_SCHED_CONTENTION_CHECK_EN enables the
//   sticky drive/readback contention detector; otherwise contention is 0.
//   Ports:
//     clk, resetn     : clock, asynchronous active-low reset
//     req             : per-requester request / beat valid
//     req_last        : final beat of a burst
//     req_data        : beat data, requester i on [i*WIDTH +: WIDTH]
//     gnt             : registered one-hot grant
//     io_o            : registered bus drive value
//     io_t            : tristate control (1 = released), all bits equal
//     io_i            : bus value from the pad buffer
//     mon_data        : io_i registered every cycle
//     mon_valid       : mon_data was captured while the bus was released
//     contention      : sticky drive/readback mismatch flag
//     contention_clr  : clears contention (set wins)
module io_bus_sched
  import io_bus_sched_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int NUM_REQ    = 2,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         io_o,
  output logic [WIDTH-1:0]         io_t,
  input  logic [WIDTH-1:0]         io_i,
  output logic [WIDTH-1:0]         mon_data,
  output logic                     mon_valid,
  output logic                     contention,
  input  logic                     contention_clr
);

  localparam int BW = cnt_width(MAX_HOLD);
  localparam int TW = cnt_width(TURNAROUND);
  localparam logic [BW-1:0] HOLD_LAST = BW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_INIT = TW'(TURNAROUND);

  state_e             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WIDTH-1:0]   r_io_o;
  logic               r_io_t;
  logic [BW-1:0]      r_beat_cnt;
  logic [TW-1:0]      r_turn_cnt;
  logic [WIDTH-1:0]   r_mon_data;
  logic               r_mon_valid;

  logic [WIDTH-1:0]   w_slice [NUM_REQ];
  logic [WIDTH-1:0]   w_gnt_data;
  logic               w_beat;
  logic               w_last;
  logic               w_end;
  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_winner;

  // Data of the granted requester: mask every slice by its grant bit, OR.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slice[gi] = req_data[gi*WIDTH +: WIDTH] & {WIDTH{r_gnt[gi]}};
    end
  endgenerate

  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt_data = w_gnt_data | w_slice[k];
    end
  end

  assign w_beat = (r_state == DRIVE) && (|(r_gnt & req));
  assign w_last = |(r_gnt & req_last);
  // A dropped request, a last beat and the hold limit all end the burst;
  // coinciding conditions are one end.
  assign w_end  = (r_state == DRIVE) &&
                  (!w_beat || w_last || (r_beat_cnt == HOLD_LAST));

  // While a burst runs, the arbiter sees only the owner, so its winner is
  // the owner and the update at burst end moves the pointer past it.
  assign w_arb_req = (r_state == DRIVE) ? r_gnt : req;

  io_bus_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (w_arb_req),
    .i_update (w_end),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_io_o     <= '0;
      r_io_t     <= 1'b1;
      r_beat_cnt <= '0;
      r_turn_cnt <= '0;
    end else begin
      // The bus is driven only in the cycle after an accepted beat.
      r_io_t <= 1'b1;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt      <= w_winner;
            r_state    <= DRIVE;
            r_beat_cnt <= '0;
          end
        end
        DRIVE: begin
          if (w_beat) begin
            r_io_o     <= w_gnt_data;
            r_io_t     <= 1'b0;
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
          if (w_end) begin
            r_gnt      <= '0;
            r_state    <= TURN;
            r_turn_cnt <= TURN_INIT;
          end
        end
        TURN: begin
          if (r_turn_cnt == '0) r_state <= IDLE;
          else                  r_turn_cnt <= r_turn_cnt - TW'(1);
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mon_data  <= '0;
      r_mon_valid <= 1'b0;
    end else begin
      r_mon_data  <= io_i;
      r_mon_valid <= r_io_t;
    end
  end

`ifdef IO_BUS_SCHED_CONTENTION_CHECK_EN
  logic r_contention;

  // Set has priority over a clear on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_contention <= 1'b0;
    end else if (!r_io_t && (io_i != r_io_o)) begin
      r_contention <= 1'b1;
    end else if (contention_clr) begin
      r_contention <= 1'b0;
    end
  end

  assign contention = r_contention;
`else
  logic w_unused_clr;
  assign w_unused_clr = contention_clr;
  assign contention   = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign io_o      = r_io_o;
  assign io_t      = {WIDTH{r_io_t}};
  assign mon_data  = r_mon_data;
  assign mon_valid = r_mon_valid;

endmodule

// File: tb/tb_io_bus_sched.sv
module tb_io_bus_sched;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int MH = 4;
  localparam int TA = 1;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   io_o;
  logic [W-1:0]   io_t;
  logic [W-1:0]   io_i;
  logic [W-1:0]   mon_data;
  logic           mon_valid;
  logic           contention;
  logic           contention_clr = 1'b0;
  logic           force_cont = 1'b0;
  logic [W-1:0]   ext_val = '0;
  logic           chk_on = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // Bus model: loopback while driven, external value while released,
  // or the inverse of the drive value to provoke contention.
  assign io_i = force_cont ? ~io_o : (io_t[0] ? ext_val : io_o);

  io_bus_sched #(
    .WIDTH(W), .NUM_REQ(N), .MAX_HOLD(MH), .TURNAROUND(TA)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_last(req_last),
    .req_data(req_data), .gnt(gnt), .io_o(io_o), .io_t(io_t), .io_i(io_i),
    .mon_data(mon_data), .mon_valid(mon_valid), .contention(contention),
    .contention_clr(contention_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bus ownership timeline: who owns the bus, how many beats it has had,
  // and the first edge at which a new owner may be chosen.
  int           m_owner, m_beats, m_last, m_idle_from, m_cyc;
  logic [N-1:0] e_gnt;
  logic [W-1:0] e_io_o, e_mon_data;
  logic         e_io_t, e_mon_valid, e_cont;

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_last = N - 1; m_idle_from = 0; m_cyc = 0;
    e_gnt = '0; e_io_o = '0; e_io_t = 1'b1;
    e_mon_data = '0; e_mon_valid = 1'b0; e_cont = 1'b0;
  endtask

  task automatic finish_burst();
    m_last = m_owner;
    m_owner = -1;
    // TURNAROUND+1 turn cycles, then one idle edge where the pick happens.
    m_idle_from = m_cyc + TA + 2;
  endtask

  task automatic model_edge();
    logic found;
`ifdef IO_BUS_SCHED_CONTENTION_CHECK_EN
    if (!e_io_t && (io_i != e_io_o)) e_cont = 1'b1;
    else if (contention_clr)         e_cont = 1'b0;
`endif
    e_mon_data  = io_i;
    e_mon_valid = e_io_t;
    e_io_t = 1'b1;
    if (m_owner >= 0) begin
      if (req[m_owner]) begin
        e_io_o = req_data[m_owner*W +: W];
        e_io_t = 1'b0;
        m_beats++;
        if (req_last[m_owner] || m_beats == MH) finish_burst();
      end else begin
        finish_burst();
      end
    end else if (m_cyc >= m_idle_from && req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_last + k) % N]) begin
          found = 1'b1;
          m_owner = (m_last + k) % N;
        end
      end
      m_beats = 0;
    end
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    m_cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else         model_edge();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model gnt",        32'(gnt),        32'(e_gnt));
      chk("model io_o",       32'(io_o),       32'(e_io_o));
      chk("model io_t",       32'(io_t),       32'({W{e_io_t}}));
      chk("model mon_data",   32'(mon_data),   32'(e_mon_data));
      chk("model mon_valid",  32'(mon_valid),  32'(e_mon_valid));
      chk("model contention", 32'(contention), 32'(e_cont));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    req = r; req_last = l; req_data = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    set_in('0, '0, '0);
    force_cont = 1'b0; contention_clr = 1'b0; ext_val = '0;
    chk_on = 1'b1;
    #1;
    chk("reset gnt",        32'(gnt),        0);
    chk("reset io_t",       32'(io_t),       32'hF);
    chk("reset io_o",       32'(io_o),       0);
    chk("reset mon_data",   32'(mon_data),   0);
    chk("reset mon_valid",  32'(mon_valid),  0);
    chk("reset contention", 32'(contention), 0);
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int got [4];
    int ng;
    logic [N-1:0] g_hist [12];
    logic         t_hist [12];
    int first_lo, lo_run, hi_run;

    // Single burst: data 1,0,1 from requester 0, last on the third beat.
    do_reset();
    set_in(3'b001, 3'b000, 12'h001);
    cyc(); chk("burst grant",   32'(gnt), 1); chk("burst io_t pre", 32'(io_t), 32'hF);
    cyc(); chk("burst b1 io_t", 32'(io_t), 0); chk("burst b1 io_o", 32'(io_o), 1);
    req_data = 12'h000;
    cyc(); chk("burst b2 io_t", 32'(io_t), 0); chk("burst b2 io_o", 32'(io_o), 0);
    set_in(3'b001, 3'b001, 12'h001);
    cyc(); chk("burst b3 io_t", 32'(io_t), 0); chk("burst b3 io_o", 32'(io_o), 1);
    chk("burst end gnt", 32'(gnt), 0);
    req_last = '0;
    cyc(); chk("gap1 io_t", 32'(io_t), 32'hF); chk("gap1 gnt", 32'(gnt), 0);
    cyc(); chk("gap2 io_t", 32'(io_t), 32'hF); chk("gap2 gnt", 32'(gnt), 0);
    cyc(); chk("gap3 io_t", 32'(io_t), 32'hF); chk("regrant gnt", 32'(gnt), 1);
    cyc(); chk("redrive io_t", 32'(io_t), 0);
    req = '0;
    cyc();

    // Round-robin with 1-beat bursts from requesters 0 and 1.
    do_reset();
    set_in(3'b011, 3'b011, 12'h021);
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      cyc();
      if (gnt != '0) begin got[ng] = 32'(gnt); ng++; end
    end
    chk("rr grant count", ng, 4);
    for (int k = 0; k < ng; k++) chk("rr grant order", got[k], (k % 2 == 0) ? 1 : 2);

    // Hold limit: requester 1 alone, no last.
    do_reset();
    set_in(3'b010, 3'b000, 12'h0A0);
    for (int c = 0; c < 12; c++) begin
      cyc();
      g_hist[c] = gnt;
      t_hist[c] = io_t[0];
    end
    first_lo = -1; lo_run = 0; hi_run = 0;
    for (int c = 0; c < 12; c++) begin
      if (first_lo < 0 && !t_hist[c]) first_lo = c;
    end
    for (int c = 0; c < 12; c++) begin
      if (first_lo >= 0 && c >= first_lo && c < first_lo + 8) begin
        if (!t_hist[c] && hi_run == 0) lo_run++;
        else if (t_hist[c] && lo_run > 0 && c < first_lo + lo_run + 3) hi_run++;
      end
    end
    chk("maxhold first beat", first_lo, 1);
    chk("maxhold beats", lo_run, 4);
    chk("maxhold released", hi_run, 3);
    chk("maxhold regrant 1", 32'(g_hist[7]), 32'h2);
    // Same, but requester 0 joins during the turnaround and takes the bus.
    do_reset();
    set_in(3'b010, 3'b000, 12'h0A5);
    repeat (5) cyc();
    req = 3'b011;
    repeat (3) cyc();
    chk("maxhold regrant 0", 32'(gnt), 1);
    req = '0;
    repeat (2) cyc();

    // Request dropped after two beats.
    do_reset();
    set_in(3'b001, 3'b000, 12'h005);
    repeat (3) cyc();
    req = '0;
    cyc(); chk("drop io_t", 32'(io_t), 32'hF); chk("drop gnt", 32'(gnt), 0);
    req = 3'b001;
    cyc(); chk("turn ignores req 1", 32'(gnt), 0);
    cyc(); chk("turn ignores req 2", 32'(gnt), 0);
    cyc(); chk("after turn grant", 32'(gnt), 1);
    req = '0;
    repeat (2) cyc();

    // Reset mid-burst while the pointer favours requester 1.
    do_reset();
    set_in(3'b001, 3'b001, 12'h003);
    repeat (2) cyc();
    set_in(3'b010, 3'b000, 12'h070);
    repeat (3) cyc(); chk("ptr moved grant", 32'(gnt), 2);
    cyc(); chk("pre-reset io_t", 32'(io_t), 0);
    set_in(3'b011, 3'b011, 12'h073);
    #2;
    resetn = 1'b0;
    #1;
    chk("async io_t", 32'(io_t), 32'hF);
    chk("async gnt",  32'(gnt),  0);
    chk("async io_o", 32'(io_o), 0);
    @(negedge clk); #1;
    resetn = 1'b1;
    cyc(); chk("post-reset grant", 32'(gnt), 1);
    req = '0;
    repeat (4) cyc();

    // Contention detector.
    do_reset();
    set_in(3'b001, 3'b000, 12'h006);
    repeat (2) cyc();
    force_cont = 1'b1;
    cyc();
`ifdef IO_BUS_SCHED_CONTENTION_CHECK_EN
    chk("cont set", 32'(contention), 1);
`else
    chk("cont tied 0", 32'(contention), 0);
`endif
    force_cont = 1'b0;
    cyc();
`ifdef IO_BUS_SCHED_CONTENTION_CHECK_EN
    chk("cont sticky", 32'(contention), 1);
`else
    chk("cont tied 0 b", 32'(contention), 0);
`endif
    force_cont = 1'b1; contention_clr = 1'b1;
    cyc();
`ifdef IO_BUS_SCHED_CONTENTION_CHECK_EN
    chk("cont set beats clr", 32'(contention), 1);
`else
    chk("cont tied 0 c", 32'(contention), 0);
`endif
    force_cont = 1'b0;
    cyc(); chk("cont cleared", 32'(contention), 0);
    contention_clr = 1'b0; req = '0;
    repeat (3) cyc();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]      = ($urandom_range(0, 99) < 85);
        req_last[i] = ($urandom_range(0, 3) == 0);
      end
      req_data       = (N*W)'($urandom);
      ext_val        = W'($urandom);
      force_cont     = ($urandom_range(0, 19) == 0);
      contention_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 resetn = 1'b0;
        #1 resetn = 1'b1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
